liteeth_sram_fifo_ctrl: RTL
===========================

LITEETH_SRAM_FIFO_CTRL -- requirements
Module: liteeth_sram_fifo_ctrl

Interface
REQ-001 SHALL have parameter BITS, default 32, data word width.
REQ-002 SHALL have parameter WORD_DEPTH, default 384, SRAM word count (need not be a power of two).
REQ-003 SHALL have parameter ADDR_WIDTH, default 9, SRAM address width.
REQ-004 SHALL have port sys_clk  input  1  single clock for all logic; the SRAM r0_clk and rw0_clk are tied to it externally.
REQ-005 SHALL have port sys_rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have ports sink_valid in 1, sink_ready out 1, sink_data in BITS: write-side stream, transfer when valid&ready.
REQ-007 SHALL have ports source_valid out 1, source_ready in 1, source_data out BITS: read-side stream, transfer when valid&ready.
REQ-008 SHALL have port level  output  ADDR_WIDTH+1  words held (SRAM + in-flight + output buffer).
REQ-009 SHALL have ports mem_rw0_ce_in, mem_rw0_we_in (out 1), mem_rw0_addr_in (out ADDR_WIDTH), mem_rw0_wd_in (out BITS): drive the SRAM rw0 port, write-only use.
REQ-010 SHALL have ports mem_r0_ce_in (out 1), mem_r0_addr_in (out ADDR_WIDTH), mem_r0_rd_out (in BITS): drive and consume the SRAM r0 port.

Function
REQ-011 SHALL drive a write when sink_valid&sink_ready, as follows: mem_rw0_ce_in=1, mem_rw0_we_in=1, mem_rw0_addr_in=wr_ptr, mem_rw0_wd_in=sink_data, all in the same cycle.
REQ-012 SHALL drive mem_rw0_ce_in=0 and mem_rw0_we_in=0 in every cycle without a write; no X on either port control.
REQ-013 SHALL track sram_cnt, the number of words written but not yet read-issued, in the range 0..WORD_DEPTH.
REQ-014 SHALL drive sink_ready = (sram_cnt + inflight + obuf_cnt < WORD_DEPTH); total capacity is WORD_DEPTH words.
REQ-015 SHALL issue a read (mem_r0_ce_in=1, mem_r0_addr_in=rd_ptr) when sram_cnt>0 and (obuf_cnt + inflight - pop) < 2, where pop = source_valid&source_ready.
REQ-016 SHALL count in sram_cnt only words written in earlier cycles, so a same-cycle write is never read; read-first collision with the rw0 port is impossible by construction.
REQ-017 SHALL advance wr_ptr and rd_ptr by 1 per operation and wrap them from WORD_DEPTH-1 to 0.
REQ-018 SHALL treat SRAM read latency as exactly 1 cycle: the inflight flag is set on issue and, on the next cycle, mem_r0_rd_out is captured into the output buffer.
REQ-019 SHALL sample mem_r0_rd_out only in the cycle after an issue, because the SRAM drives X when ce is low.
REQ-020 SHALL contain a 2-entry in-order output buffer (obuf_cnt 0..2); source_valid = (obuf_cnt>0); source_data = head entry, a registered value that is never X when valid.
REQ-021 SHALL hold source_data and source_valid stable while source_valid&!source_ready.
REQ-022 SHALL sustain 1 word/cycle end-to-end with sink_valid and source_ready held high.
REQ-023 SHALL have an empty-FIFO latency of 2 cycles: a word accepted at edge N is written at edge N, read-issued in cycle N+1, and captured at edge N+2 with source_valid=1 after edge N+2.
REQ-024 SHALL, on a simultaneous write and read-issue, update sram_cnt by +1-1=0; simultaneous capture and pop leaves obuf_cnt unchanged.
REQ-025 SHALL update level each cycle as the sum of sram_cnt + inflight + obuf_cnt, with the same registered timing.
REQ-026 SHALL treat sink_valid while !sink_ready as no transfer: no write occurs and the data is not dropped upstream.

Reset
REQ-027 SHALL, while sys_rst=1 at an edge, clear wr_ptr, rd_ptr, sram_cnt, inflight and obuf_cnt to 0.
REQ-028 SHALL, after reset, give source_valid=0, level=0, sink_ready=1 and all mem ce/we=0.
REQ-029 SHALL, on reset asserted mid-stream, discard all stored and in-flight words; the SRAM contents are not cleared and must not be reused.
REQ-030 SHALL ignore sink and source handshakes in reset cycles; sink_ready is 0 while sys_rst=1.

Verification
REQ-031 SHALL verify first word: push 0xA5A5_0001 into an empty FIFO at cycle 0 -> source_valid rises after edge 2, data 0xA5A5_0001, level 1 then 0 after the pop.
REQ-032 SHALL verify streaming: push 0..999 back-to-back with source_ready=1 -> all 1000 words are output in order, 1/cycle after the initial 2-cycle latency, and no sink stall occurs.
REQ-033 SHALL verify fill to full: source_ready=0, push 400 words -> sink_ready drops after word 384, level=384, and the output is words 0..383 with the pointers wrapped correctly.
REQ-034 SHALL verify wrap: run 1000 words with source_ready random at 50% and sink_valid random at 70% -> scoreboard match, and no mem_r0_addr_in or mem_rw0_addr_in value >= 384.
REQ-035 SHALL verify backpressure hold: with source_valid=1, hold source_ready=0 for 5 cycles -> source_data unchanged and no read issue beyond obuf+inflight=2.
REQ-036 SHALL verify reset mid-operation: with level=100, assert sys_rst for 1 cycle -> level=0 and source_valid=0; the next push of 0x1234 emerges as the first output.

Source files
------------

// File: rtl/liteeth_sram_fifo_ctrl.sv
// liteeth_sram_fifo_ctrl
// Stream FIFO controller around an external two-port SRAM. Port rw0 is used
// only for writes and port r0 only for reads. The SRAM has a fixed one-cycle
// read latency. A two-entry output buffer decouples that latency from the
// source handshake, so throughput stays at one word per cycle.
module liteeth_sram_fifo_ctrl #(
    parameter int BITS       = 32,
    parameter int WORD_DEPTH = 384,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  sink_valid,
    output logic                  sink_ready,
    input  logic [BITS-1:0]       sink_data,
    output logic                  source_valid,
    input  logic                  source_ready,
    output logic [BITS-1:0]       source_data,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  mem_rw0_ce_in,
    output logic                  mem_rw0_we_in,
    output logic [ADDR_WIDTH-1:0] mem_rw0_addr_in,
    output logic [BITS-1:0]       mem_rw0_wd_in,
    output logic                  mem_r0_ce_in,
    output logic [ADDR_WIDTH-1:0] mem_r0_addr_in,
    input  logic [BITS-1:0]       mem_r0_rd_out
);

    localparam int CW = ADDR_WIDTH + 1;

    // Advance a pointer, wrapping at the (possibly non power-of-two) depth.
    function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] p);
        if (p == ADDR_WIDTH'(WORD_DEPTH - 1)) begin
            ptr_inc = {ADDR_WIDTH{1'b0}};
        end else begin
            ptr_inc = p + ADDR_WIDTH'(1);
        end
    endfunction

    logic [ADDR_WIDTH-1:0] wr_ptr_r, rd_ptr_r;
    logic [CW-1:0]         sram_cnt_r, level_r;
    logic                  inflight_r;
    logic [1:0]            obuf_cnt_r;
    logic [BITS-1:0]       obuf0_r, obuf1_r;

    logic [CW-1:0]         total_s, sram_cnt_nxt_s, level_nxt_s;
    logic [2:0]            occ_s;
    logic                  push_s, pop_s, issue_s;
    logic [1:0]            obuf_cnt_nxt_s;
    logic [BITS-1:0]       obuf0_nxt_s, obuf1_nxt_s;

    assign total_s      = sram_cnt_r + CW'(inflight_r) + CW'(obuf_cnt_r);
    assign sink_ready   = !sys_rst && (total_s < CW'(WORD_DEPTH));
    assign source_valid = (obuf_cnt_r != 2'd0);
    assign source_data  = obuf0_r;
    assign level        = level_r;
    assign push_s       = sink_valid && sink_ready;
    assign pop_s        = !sys_rst && source_valid && source_ready;
    // Output-side occupancy after this cycle's pop; a read may only be issued
    // if the buffer is guaranteed a free slot when the data returns.
    assign occ_s        = {1'b0, obuf_cnt_r} + {2'b00, inflight_r} - {2'b00, pop_s};
    // sram_cnt only counts earlier writes, so a same-cycle write is never read.
    assign issue_s      = !sys_rst && (sram_cnt_r != {CW{1'b0}}) && (occ_s < 3'd2);

    assign mem_rw0_ce_in   = push_s;
    assign mem_rw0_we_in   = push_s;
    assign mem_rw0_addr_in = wr_ptr_r;
    assign mem_rw0_wd_in   = sink_data;
    assign mem_r0_ce_in    = issue_s;
    assign mem_r0_addr_in  = rd_ptr_r;

    // Next-state computation for counters and the two-entry output buffer.
    always_comb begin
        sram_cnt_nxt_s = sram_cnt_r + CW'(push_s) - CW'(issue_s);
        obuf_cnt_nxt_s = obuf_cnt_r;
        obuf0_nxt_s    = obuf0_r;
        obuf1_nxt_s    = obuf1_r;
        case ({inflight_r, pop_s})
            2'b10: begin
                obuf_cnt_nxt_s = obuf_cnt_r + 2'd1;
                if (obuf_cnt_r == 2'd0) begin
                    obuf0_nxt_s = mem_r0_rd_out;
                end else begin
                    obuf1_nxt_s = mem_r0_rd_out;
                end
            end
            2'b01: begin
                obuf_cnt_nxt_s = obuf_cnt_r - 2'd1;
                obuf0_nxt_s    = obuf1_r;
            end
            2'b11: begin
                if (obuf_cnt_r == 2'd1) begin
                    obuf0_nxt_s = mem_r0_rd_out;
                end else begin
                    obuf0_nxt_s = obuf1_r;
                    obuf1_nxt_s = mem_r0_rd_out;
                end
            end
            default: begin
                obuf_cnt_nxt_s = obuf_cnt_r;
            end
        endcase
        level_nxt_s = sram_cnt_nxt_s + CW'(issue_s) + CW'(obuf_cnt_nxt_s);
    end

    // State registers with synchronous reset; SRAM contents are left stale.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            wr_ptr_r   <= {ADDR_WIDTH{1'b0}};
            rd_ptr_r   <= {ADDR_WIDTH{1'b0}};
            sram_cnt_r <= {CW{1'b0}};
            level_r    <= {CW{1'b0}};
            inflight_r <= 1'b0;
            obuf_cnt_r <= 2'd0;
            obuf0_r    <= {BITS{1'b0}};
            obuf1_r    <= {BITS{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (issue_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            sram_cnt_r <= sram_cnt_nxt_s;
            level_r    <= level_nxt_s;
            inflight_r <= issue_s;
            obuf_cnt_r <= obuf_cnt_nxt_s;
            obuf0_r    <= obuf0_nxt_s;
            obuf1_r    <= obuf1_nxt_s;
        end
    end

endmodule
